// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared definitions for the MEM-stage mreq/mres handshake.
//            Used by both the memory responder and the MEM stage initiator.
// Contents : state_t  - responder state enum
//            WORD_W   - data word width
//            BE_W     - byte-enable width
//            LOAD_WEN - mwen encoding that marks a load
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // A request with no byte enables set is a load.
  localparam logic [BE_W-1:0] LOAD_WEN = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    READ   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : mreq/mres handshake bundle between the MEM stage (master) and
//            the memory responder (slave).
// Signals  : mreq   - request level, held until mres seen
//            maddr  - byte address
//            mwen   - byte write enables (0 = load)
//            mwdata - store data
//            mres   - response level
//            mrdata - load data, valid while mres high
//            merr   - error qualifier, valid while mres high
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  import mem_if_pkg::*;

  logic              mreq;
  logic [WORD_W-1:0] maddr;
  logic [BE_W-1:0]   mwen;
  logic [WORD_W-1:0] mwdata;
  logic              mres;
  logic [WORD_W-1:0] mrdata;
  logic              merr;

  modport master (
    output mreq, maddr, mwen, mwdata,
    input  mres, mrdata, merr
  );

  modport slave (
    input  mreq, maddr, mwen, mwdata,
    output mres, mrdata, merr
  );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_responder_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_check
// Purpose  : Combinational alignment and RAM-window check of a byte address.
// Ports    : addr (in, 32)     - byte address
//            err  (out, 1)     - misaligned or outside the RAM window
//            idx  (out, ADDR_W)- word index into the RAM
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_check
  import mem_if_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [WORD_W-1:0] addr,
  output logic              err,
  output logic [ADDR_W-1:0] idx
);

  logic w_misaligned;
  logic w_out_of_window;

  assign w_misaligned = (addr[1:0] != 2'b00);
  assign idx          = addr[ADDR_W+1:2];

  // When the RAM spans the whole address space there are no window bits.
  generate
    if (ADDR_W + 2 < WORD_W) begin : g_window
      assign w_out_of_window = (addr[WORD_W-1:ADDR_W+2] != BASE_ADDR[WORD_W-1:ADDR_W+2]);
    end else begin : g_no_window
      assign w_out_of_window = 1'b0;
    end
  endgenerate

  assign err = w_misaligned | w_out_of_window;

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the MEM stage mreq/mres handshake.
//            Serves one word request at a time (load or byte-enabled store)
//            against a synchronous RAM with 1-cycle read latency.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            bus (slave modport)  - mreq/maddr/mwen/mwdata in, mres/mrdata/merr out
//            ram_en, ram_we       - RAM enable and byte write enables
//            ram_addr, ram_din    - RAM word address and write data
//            ram_dout             - RAM read data (one cycle after ram_en)
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_din,
  input  logic [WORD_W-1:0] ram_dout
);

  localparam logic [3:0] C_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state,  w_state_nxt;
  logic [3:0]        r_cnt,    w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx,    w_idx_nxt;
  logic [BE_W-1:0]   r_wen,    w_wen_nxt;
  logic [WORD_W-1:0] r_wdata,  w_wdata_nxt;
  logic              r_mres,   w_mres_nxt;
  logic              r_merr,   w_merr_nxt;
  logic [WORD_W-1:0] r_mrdata, w_mrdata_nxt;

  logic              w_err;
  logic [ADDR_W-1:0] w_idx;

  // Only the word index of the address is needed after the check, so that
  // is what gets latched.
  mem_addr_check #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_check (
    .addr (bus.maddr),
    .err  (w_err),
    .idx  (w_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_wen_nxt    = r_wen;
    w_wdata_nxt  = r_wdata;
    w_mres_nxt   = r_mres;
    w_merr_nxt   = r_merr;
    w_mrdata_nxt = r_mrdata;
    ram_en       = 1'b0;
    ram_we       = '0;

    case (r_state)
      IDLE: begin
        if (bus.mreq) begin
          w_idx_nxt   = w_idx;
          w_wen_nxt   = bus.mwen;
          w_wdata_nxt = bus.mwdata;
          if (w_err) begin
            w_state_nxt = DONE;
            w_mres_nxt  = 1'b1;
            w_merr_nxt  = 1'b1;
          end else if (WAIT_CYCLES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = C_WAIT_INIT;
          end else begin
            w_state_nxt = ACCESS;
          end
        end
      end

      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ACCESS: begin
        ram_en      = 1'b1;
        ram_we      = r_wen;
        w_state_nxt = READ;
      end

      READ: begin
        // Stores leave the previous load data visible.
        if (r_wen == LOAD_WEN) begin
          w_mrdata_nxt = ram_dout;
        end
        w_mres_nxt  = 1'b1;
        w_merr_nxt  = 1'b0;
        w_state_nxt = DONE;
      end

      DONE: begin
        if (!bus.mreq) begin
          w_mres_nxt  = 1'b0;
          w_merr_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Suppress any RAM write in the reset cycle itself.
    if (reset) begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_wen    <= '0;
      r_wdata  <= '0;
      r_mres   <= 1'b0;
      r_merr   <= 1'b0;
      r_mrdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_wen    <= w_wen_nxt;
      r_wdata  <= w_wdata_nxt;
      r_mres   <= w_mres_nxt;
      r_merr   <= w_merr_nxt;
      r_mrdata <= w_mrdata_nxt;
    end
  end

  assign ram_addr   = r_idx;
  assign ram_din    = r_wdata;
  assign bus.mres   = r_mres;
  assign bus.merr   = r_merr;
  assign bus.mrdata = r_mrdata;

endmodule : mem_responder
`default_nettype wire
